// File: rtl/operand_select_pipe_if.sv
// Request/response bundle for operand_select_pipe: M*N-bit operand request in,
// one registered N-bit operand word out, both with valid/ready flow control.
interface operand_select_pipe_if #(
  parameter int N = 233,
  parameter int M = 4
);
  localparam int SELW = (M > 1) ? $clog2(M) : 1;

  logic [M*N-1:0]  in_data;
  logic [SELW-1:0] sel;
  logic            mode;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  modport master (
    output in_data, sel, mode, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_last, out_valid, busy
  );

  modport slave (
    input  in_data, sel, mode, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_last, out_valid, busy
  );
endinterface

// File: rtl/operand_select_pipe.sv
// Registered M-way operand selector: DIRECT passes one channel per request,
// SEQUENCE captures all channels and streams them out in rotating order.
module operand_select_pipe #(
  parameter int N = 233,
  parameter int M = 4
) (
  input logic                  clk,
  input logic                  rst,
  operand_select_pipe_if.slave bus
);
  localparam int SELW = (M > 1) ? $clog2(M) : 1;
  localparam int CNTW = $clog2(M + 1);

  typedef enum logic {IDLE, SEQ} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    buf_q [M];
  logic            buf_we;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;

  logic [N-1:0]    in_words [M];
  logic [SELW-1:0] ch;
  logic            slot_free;
  logic            in_ready;
  logic            accept;

  for (genvar k = 0; k < M; k++) begin : g_unpack
    assign in_words[k] = bus.in_data[k*N +: N];
  end

  function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] p);
    return (p == SELW'(M - 1)) ? '0 : p + 1'b1;
  endfunction

  // Out-of-range selects fall back to the top channel.
  assign ch        = (int'(bus.sel) >= M) ? SELW'(M - 1) : bus.sel;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    buf_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_data_d  = in_words[ch];
          out_chan_d  = ch;
          out_valid_d = 1'b1;
          if (!bus.mode) begin
            out_last_d = 1'b1;
          end else begin
            // First sequence word comes straight from in_data while the buffer loads.
            out_last_d = 1'b0;
            buf_we     = 1'b1;
            ptr_d      = next_ptr(ch);
            cnt_d      = CNTW'(1);
            state_d    = SEQ;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      SEQ: begin
        if (slot_free) begin
          out_data_d  = buf_q[ptr_q];
          out_chan_d  = ptr_q;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == CNTW'(M - 1));
          ptr_d       = next_ptr(ptr_q);
          cnt_d       = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(M - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      for (int unsigned k = 0; k < M; k++) buf_q[k] <= in_words[k];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == SEQ);
endmodule

// File: tb/tb_operand_select_pipe.sv
// Scoreboard bench for operand_select_pipe: M=4 main instance plus an M=3
// instance for the non-power-of-two wrap and top-channel fallback.
module tb_operand_select_pipe;
  localparam int N  = 233;
  localparam int M  = 4;
  localparam int M3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_select_pipe_if #(.N(N), .M(M))  bus4 ();
  operand_select_pipe_if #(.N(N), .M(M3)) bus3 ();

  operand_select_pipe #(.N(N), .M(M))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
  operand_select_pipe #(.N(N), .M(M3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic [N-1:0] data;
    int           chan;
    bit           last;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rnd_word();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
    return t[N-1:0];
  endfunction

  function automatic logic [M*N-1:0] rnd_bus();
    logic [M*N-1:0] r;
    for (int k = 0; k < M; k++) r[k*N +: N] = rnd_word();
    return r;
  endfunction

  // Reference: a request expands into the list of words it must produce.
  task automatic expand(input int mm, input bit md, input int s, input logic [M*N-1:0] d,
                        inout exp_t q[$]);
    int   c;
    exp_t e;
    c = (s >= mm) ? mm - 1 : s;
    if (!md) begin
      e.data = d[c*N +: N]; e.chan = c; e.last = 1'b1;
      q.push_back(e);
    end else begin
      for (int i = 0; i < mm; i++) begin
        e.data = d[((c + i) % mm)*N +: N];
        e.chan = (c + i) % mm;
        e.last = (i == mm - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic cyc4(input bit v, input bit md, input int s, input logic [M*N-1:0] d,
                      input bit ordy);
    bit acc;
    @(negedge clk);
    bus4.in_valid = v; bus4.mode = md; bus4.sel = 2'(s); bus4.in_data = d;
    bus4.out_ready = ordy;
    #1;
    chk("in_ready4", bus4.in_ready, (q4.size() <= 1) && (q4.size() == 0 || ordy));
    acc = v && bus4.in_ready;
    @(posedge clk);
    if (acc) expand(M, md, s, d, q4);
  endtask

  task automatic cyc3(input bit v, input bit md, input int s, input logic [M*N-1:0] d);
    bit acc;
    @(negedge clk);
    bus3.in_valid = v; bus3.mode = md; bus3.sel = 2'(s); bus3.in_data = d[M3*N-1:0];
    bus3.out_ready = 1'b1;
    #1;
    chk("in_ready3", bus3.in_ready, q3.size() <= 1);
    acc = v && bus3.in_ready;
    @(posedge clk);
    if (acc) expand(M3, md, s, d, q3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
    @(posedge clk);
    q4.delete();
    q3.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", bus4.out_valid, 1'b0);
    chk("rst_busy",  bus4.busy,      1'b0);
    chk("rst_last",  bus4.out_last,  1'b0);
    chk("rst_data",  bus4.out_data,  '0);
    chk("rst_chan",  bus4.out_chan,  '0);
    chk("rst_ready", bus4.in_ready,  1'b1);
  endtask

  always begin : mon4
    bit   take;
    exp_t e;
    @(negedge clk);
    #2;
    take = 1'b0;
    if (!rst) begin
      chk("valid4", bus4.out_valid, q4.size() != 0);
      chk("busy4",  bus4.busy,      q4.size() >= 2);
      if (bus4.out_valid && q4.size() != 0) begin
        e = q4[0];
        chk("data4", bus4.out_data, e.data);
        chk("chan4", bus4.out_chan, e.chan);
        chk("last4", bus4.out_last, e.last);
        take = bus4.out_ready;
      end
    end
    @(posedge clk);
    if (take) void'(q4.pop_front());
  end

  always begin : mon3
    bit   take;
    exp_t e;
    @(negedge clk);
    #2;
    take = 1'b0;
    if (!rst) begin
      chk("valid3", bus3.out_valid, q3.size() != 0);
      chk("busy3",  bus3.busy,      q3.size() >= 2);
      if (bus3.out_valid && q3.size() != 0) begin
        e = q3[0];
        chk("data3", bus3.out_data, e.data);
        chk("chan3", bus3.out_chan, e.chan);
        chk("last3", bus3.out_last, e.last);
        take = bus3.out_ready;
      end
    end
    @(posedge clk);
    if (take) void'(q3.pop_front());
  end

  initial begin : watchdog
    #700000;
    failures++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic [M*N-1:0] d, d2;
    logic [N-1:0]   a, b, c, dd;
    int             accepted, budget;

    bus4.in_valid = 1'b0; bus4.mode = 1'b0; bus4.sel = '0; bus4.in_data = '0; bus4.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.mode = 1'b0; bus3.sel = '0; bus3.in_data = '0; bus3.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    // Legacy {A,B,C,D} DIRECT sweep, no backpressure.
    a = rnd_word(); b = rnd_word(); c = rnd_word(); dd = rnd_word();
    d = {a, b, c, dd};
    for (int s = 0; s < 4; s++) cyc4(1'b1, 1'b0, s, d, 1'b1);
    cyc4(1'b0, 1'b0, 0, d, 1'b1);

    // Backpressure on a DIRECT word.
    cyc4(1'b1, 1'b0, 2, d, 1'b1);
    for (int i = 0; i < 5; i++) cyc4(1'b0, 1'b0, 0, rnd_bus(), 1'b0);
    cyc4(1'b0, 1'b0, 0, d, 1'b1);
    cyc4(1'b0, 1'b0, 0, d, 1'b1);

    // SEQUENCE from channel 3 with in_data scrambled afterwards.
    cyc4(1'b1, 1'b1, 3, d, 1'b1);
    for (int i = 0; i < 5; i++) cyc4(1'b0, 1'b0, 0, rnd_bus(), 1'b1);

    // M=3: wrap 2,0,1 then DIRECT sel=3 falls back to channel 2.
    d2 = rnd_bus();
    cyc3(1'b1, 1'b1, 2, d2);
    for (int i = 0; i < 3; i++) cyc3(1'b0, 1'b0, 0, rnd_bus());
    cyc3(1'b1, 1'b0, 3, d2);
    cyc3(1'b0, 1'b0, 0, d2);
    cyc3(1'b0, 1'b0, 0, d2);

    // Reset while the second SEQ word is stalled.
    cyc4(1'b1, 1'b1, 1, rnd_bus(), 1'b1);
    cyc4(1'b0, 1'b0, 0, d, 1'b1);
    cyc4(1'b0, 1'b0, 0, d, 1'b0);
    do_reset();
    cyc4(1'b1, 1'b0, 2, d, 1'b1);
    cyc4(1'b0, 1'b0, 0, d, 1'b1);
    cyc4(1'b0, 1'b0, 0, d, 1'b1);

    // Mixed random traffic with random backpressure.
    accepted = 0;
    budget   = 0;
    while (accepted < 1000 && budget < 30000) begin
      bit v, md, ordy;
      int s;
      v    = ($urandom_range(0, 9) < 7);
      md   = $urandom_range(0, 1);
      s    = $urandom_range(0, M - 1);
      ordy = $urandom_range(0, 1);
      d    = rnd_bus();
      @(negedge clk);
      bus4.in_valid = v; bus4.mode = md; bus4.sel = 2'(s); bus4.in_data = d;
      bus4.out_ready = ordy;
      #1;
      chk("in_ready4r", bus4.in_ready, (q4.size() <= 1) && (q4.size() == 0 || ordy));
      if (v && bus4.in_ready) begin
        accepted++;
        @(posedge clk);
        expand(M, md, s, d, q4);
      end else begin
        @(posedge clk);
      end
      budget++;
    end
    chk("random_accepted", accepted, 1000);

    budget = 0;
    while (q4.size() != 0 && budget < 50) begin
      cyc4(1'b0, 1'b0, 0, rnd_bus(), 1'b1);
      budget++;
    end
    cyc4(1'b0, 1'b0, 0, '0, 1'b1);
    chk("drain_empty", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
